// File: rtl/input_stream_driver_if.sv
// Pixel-stream driver bundle: image-memory read port, start handshake and pixel stream.
// master = the driver, slave = the image store / input-layer side.
interface input_stream_driver_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) ();
    logic              startImage;
    logic [ADDR_W-1:0] imageBase;
    logic              readyForInputs;
    logic [ADDR_W-1:0] memAddr;
    logic              memRead;
    logic [DATA_W-1:0] memData;
    logic              inputsInbound;
    logic              pixelValue;
    logic              busy;
    logic              doneImage;
    logic [15:0]       imagesSent;

    modport master (
        input  startImage, imageBase, readyForInputs, memData,
        output memAddr, memRead, inputsInbound, pixelValue, busy, doneImage, imagesSent
    );

    modport slave (
        output startImage, imageBase, readyForInputs, memData,
        input  memAddr, memRead, inputsInbound, pixelValue, busy, doneImage, imagesSent
    );
endinterface

// File: rtl/input_stream_driver.sv
// Reads one image from a synchronous memory, binarizes each pixel against THRESHOLD
// and streams NUM_PIXELS one-bit pixels on consecutive cycles to the input layer.
module input_stream_driver #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int THRESHOLD  = 128
) (
    input logic                  clk,
    input logic                  reset,
    input_stream_driver_if.master bus
);
    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0]  LAST_PIXEL = CNT_W'(NUM_PIXELS - 1);
    localparam logic [DATA_W-1:0] THRESH     = DATA_W'(THRESHOLD);

    typedef enum logic [1:0] {IDLE, WAIT_READY, STREAM, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic              memRead_q, memRead_d;
    logic              rdValid_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pixel_q, pixel_d;
    logic              inbound_q, inbound_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       sent_q, sent_d;

    // rdValid_q marks the cycle in which memData holds the word requested one cycle earlier;
    // pixels are registered exactly on those cycles, which also delimits the DRAIN state.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        memAddr_d = memAddr_q;
        memRead_d = memRead_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        sent_d    = sent_q;
        done_d    = 1'b0;
        inbound_d = rdValid_q;
        pixel_d   = rdValid_q ? (bus.memData >= THRESH) : 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.startImage) begin
                    base_d  = bus.imageBase;
                    busy_d  = 1'b1;
                    state_d = WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (bus.readyForInputs) begin
                    memAddr_d = base_q;
                    memRead_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                memAddr_d = memAddr_q + 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_PIXEL) begin
                    memRead_d = 1'b0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (!rdValid_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    sent_d  = sent_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            memAddr_q <= '0;
            memRead_q <= 1'b0;
            rdValid_q <= 1'b0;
            cnt_q     <= '0;
            pixel_q   <= 1'b0;
            inbound_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            memAddr_q <= memAddr_d;
            memRead_q <= memRead_d;
            rdValid_q <= memRead_q;
            cnt_q     <= cnt_d;
            pixel_q   <= pixel_d;
            inbound_q <= inbound_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sent_q    <= sent_d;
        end
    end

    assign bus.memAddr       = memAddr_q;
    assign bus.memRead       = memRead_q;
    assign bus.inputsInbound = inbound_q;
    assign bus.pixelValue    = pixel_q;
    assign bus.busy          = busy_q;
    assign bus.doneImage     = done_q;
    assign bus.imagesSent    = sent_q;
endmodule

// File: tb/tb_input_stream_driver.sv
// Directed bench for input_stream_driver: ramp-pattern memory model, expected pixels and
// addresses queued when an image is requested and popped as the DUT streams them out.
module tb_input_stream_driver;
    localparam int NPIX = 784;

    logic clk = 1'b0;
    logic reset;

    input_stream_driver_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    input_stream_driver #(
        .NUM_PIXELS(NPIX), .ADDR_W(16), .DATA_W(8), .THRESHOLD(128)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory returns the low address byte one cycle after a read request.
    always @(posedge clk) begin
        if (bus.memRead === 1'b1) bus.memData <= bus.memAddr[7:0];
    end

    int total = 0;
    int bad = 0;
    int inbRun = 0;
    int lastRun = 0;
    int lowRun = 0;
    int lastGap = 0;
    int doneCount = 0;
    int readCount = 0;
    bit expQ[$];
    logic [15:0] addrQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [15:0] base, input logic ready);
        bus.startImage     = start;
        bus.imageBase      = base;
        bus.readyForInputs = ready;
    endtask

    task automatic pushImage(input logic [15:0] base);
        for (int i = 0; i < NPIX; i++) begin
            logic [15:0] a;
            a = base + 16'(i);
            expQ.push_back(a[7:0] >= 8'd128);
            addrQ.push_back(a);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".memAddr"}, bus.memAddr, 0);
        checkOutput({tag, ".memRead"}, bus.memRead, 0);
        checkOutput({tag, ".inbound"}, bus.inputsInbound, 0);
        checkOutput({tag, ".pixel"}, bus.pixelValue, 0);
        checkOutput({tag, ".busy"}, bus.busy, 0);
        checkOutput({tag, ".done"}, bus.doneImage, 0);
        checkOutput({tag, ".sent"}, bus.imagesSent, 0);
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.doneImage !== 1'b1 && n < 3000);
        checkOutput(tag, bus.doneImage, 1);
    endtask

    task automatic waitRun(input string tag, input int target);
        int n = 0;
        while (inbRun < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, inbRun >= target, 1);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        addrQ.delete();
    endtask

    // Scoreboard side: every streamed pixel and every issued read is matched against the queues.
    always @(negedge clk) begin
        if (bus.inputsInbound === 1'b1) begin
            if (expQ.size() == 0) checkOutput("pixelExtra", 1, 0);
            else checkOutput("pixel", bus.pixelValue, expQ.pop_front());
            if (inbRun == 0) lastGap = lowRun;
            inbRun++;
            lowRun = 0;
        end else begin
            if (inbRun > 0) lastRun = inbRun;
            inbRun = 0;
            lowRun++;
        end
        if (bus.doneImage === 1'b1) doneCount++;
        if (bus.memRead === 1'b1) begin
            readCount++;
            if (addrQ.size() == 0) checkOutput("readExtra", 1, 0);
            else checkOutput("memAddr", bus.memAddr, addrQ.pop_front());
        end
    end

    initial begin
        int cyc;
        int dc;
        int rc;
        logic anyRead;

        $display("[TB] start");
        applyStimulus(1'b0, 16'h0000, 1'b0);
        doReset();
        checkResetValues("reset");

        // Ramp image with ready already high: latency, length, one done pulse.
        pushImage(16'h0000);
        rc = readCount;
        applyStimulus(1'b1, 16'h0000, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                applyStimulus(1'b0, 16'h0000, 1'b1);
                checkOutput("rampBusy", bus.busy, 1);
            end
        end while (bus.inputsInbound !== 1'b1 && cyc < 50);
        checkOutput("rampLatency", cyc, 4);
        waitDone("rampDone");
        @(negedge clk);
        checkOutput("rampDonePulse", bus.doneImage, 0);
        checkOutput("rampRun", lastRun, NPIX);
        checkOutput("rampReads", readCount - rc, NPIX);
        checkOutput("rampDoneCount", doneCount, 1);
        checkOutput("rampSent", bus.imagesSent, 1);
        checkOutput("rampBusyLow", bus.busy, 0);
        checkOutput("rampQueue", expQ.size(), 0);

        // Ready gating, then a mid-stream drop of ready that must be ignored.
        pushImage(16'h1000);
        applyStimulus(1'b1, 16'h1000, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'h1000, 1'b0);
        anyRead = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            anyRead = anyRead | (bus.memRead === 1'b1);
        end
        checkOutput("gateNoRead", anyRead, 0);
        checkOutput("gateBusy", bus.busy, 1);
        applyStimulus(1'b0, 16'h1000, 1'b1);
        @(negedge clk);
        checkOutput("gateAddr", bus.memAddr, 16'h1000);
        checkOutput("gateRead", bus.memRead, 1);
        checkOutput("gateInbK", bus.inputsInbound, 0);
        @(negedge clk);
        checkOutput("gateInbK1", bus.inputsInbound, 0);
        @(negedge clk);
        checkOutput("gateInbK2", bus.inputsInbound, 1);
        repeat (50) @(negedge clk);
        applyStimulus(1'b0, 16'h1000, 1'b0);
        waitDone("gateDone");
        @(negedge clk);
        checkOutput("gateRun", lastRun, NPIX);
        checkOutput("gateSent", bus.imagesSent, 2);

        // Address wrap past 16'hFFFF.
        pushImage(16'hFFF0);
        rc = readCount;
        applyStimulus(1'b1, 16'hFFF0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'hFFF0, 1'b1);
        waitDone("wrapDone");
        @(negedge clk);
        checkOutput("wrapReads", readCount - rc, NPIX);
        checkOutput("wrapAddrQ", addrQ.size(), 0);
        checkOutput("wrapRun", lastRun, NPIX);
        checkOutput("wrapSent", bus.imagesSent, 3);

        // Reset around pixel 400 discards the image; a fresh image then streams fully.
        pushImage(16'h0000);
        dc = doneCount;
        applyStimulus(1'b1, 16'h0000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        waitRun("midRun", 400);
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("midReset");
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        addrQ.delete();
        lastRun = 0;
        checkOutput("midNoDone", doneCount, dc);
        pushImage(16'h0000);
        applyStimulus(1'b1, 16'h0000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        waitDone("midDone");
        @(negedge clk);
        checkOutput("midRun784", lastRun, NPIX);
        checkOutput("midSent", bus.imagesSent, 1);

        // Busy/back-to-back: ignored mid-stream pulse, then start held through doneImage.
        doReset();
        pushImage(16'h0000);
        pushImage(16'h0000);
        dc = doneCount;
        applyStimulus(1'b1, 16'h0000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        waitRun("b2bRun100", 100);
        applyStimulus(1'b1, 16'h0000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        waitRun("b2bRun700", 700);
        applyStimulus(1'b1, 16'h0000, 1'b1);
        waitDone("b2bDone1");
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("b2bAccepted", bus.busy, 1);
        checkOutput("b2bSent1", bus.imagesSent, 1);
        waitDone("b2bDone2");
        @(negedge clk);
        checkOutput("b2bGap", lastGap >= 2, 1);
        checkOutput("b2bRun", lastRun, NPIX);
        checkOutput("b2bDoneCount", doneCount - dc, 2);
        checkOutput("b2bSent2", bus.imagesSent, 2);
        checkOutput("b2bQueue", expQ.size(), 0);
        repeat (5) @(negedge clk);
        checkOutput("b2bIdle", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
